// File: rtl/controlador_preempcao_if.sv
// CPU <-> preemption controller signal bundle: retire/stall/io status in, preemption request out.
// Latency: pure wiring, no storage.
// Backpressure: none; the request is held by the controller until troca_ack or cancel.
interface controlador_preempcao_if #(
  parameter int PC_W = 32
);
  logic [PC_W-1:0] pc;
  logic            avanco;
  logic            parada;
  logic            instrucao_io;
  logic            fim_processo;
  logic            troca_ack;
  logic            troca_contexto;
  logic [PC_W-1:0] pc_salvo;
  logic [7:0]      restante;
  logic [7:0]      num_trocas;

  // CPU side: drives status, receives the preemption request
  modport master (
    output pc, avanco, parada, instrucao_io, fim_processo, troca_ack,
    input  troca_contexto, pc_salvo, restante, num_trocas
  );

  // Controller side
  modport slave (
    input  pc, avanco, parada, instrucao_io, fim_processo, troca_ack,
    output troca_contexto, pc_salvo, restante, num_trocas
  );
endinterface

// File: rtl/controlador_preempcao.sv
// Time-slice preemption: counts retired user instructions and requests a context switch after QUANTUM.
// Latency: troca_contexto rises one cycle after the retire strobe that completes the slice (unless deferred).
// Backpressure: request deferred while IN/OUT runs or CPU is halted; held until troca_ack or fim_processo.
module controlador_preempcao #(
  parameter int QUANTUM = 8,
  parameter int AREA_SO = 300,
  parameter int PC_W    = 32
) (
  input logic clock,
  input logic reset,
  controlador_preempcao_if.slave cpu
);

  localparam logic [7:0]      QUANTUM_C  = 8'(QUANTUM);
  localparam logic [PC_W-1:0] AREA_SO_PC = PC_W'(AREA_SO);

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    CONTANDO = 2'd1,
    PENDENTE = 2'd2,
    REQ      = 2'd3
  } estado_t;

  estado_t         state, stateNext;
  logic [7:0]      contador, contadorNext;
  logic            trocaReg, trocaNext;
  logic [PC_W-1:0] pcSalvoReg, pcSalvoNext;
  logic [7:0]      numTrocasReg, numTrocasNext;
  logic            usuario;
  logic            contaPasso;

  assign usuario = (cpu.pc >= AREA_SO_PC);

  // State and output registers; reset drops the request immediately
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= OCIOSO;
      contador     <= 8'd0;
      trocaReg     <= 1'b0;
      pcSalvoReg   <= '0;
      numTrocasReg <= 8'd0;
    end else begin
      state        <= stateNext;
      contador     <= contadorNext;
      trocaReg     <= trocaNext;
      pcSalvoReg   <= pcSalvoNext;
      numTrocasReg <= numTrocasNext;
    end
  end

  // Next state: process end beats ack, ack beats OS-region cancel, cancel beats counting
  always_comb begin
    stateNext     = state;
    contadorNext  = contador;
    trocaNext     = trocaReg;
    pcSalvoNext   = pcSalvoReg;
    numTrocasNext = numTrocasReg;
    contaPasso    = cpu.avanco && usuario && !cpu.parada;

    if (cpu.fim_processo) begin
      stateNext    = OCIOSO;
      contadorNext = 8'd0;
      trocaNext    = 1'b0;
    end else if (cpu.troca_ack && (state == REQ)) begin
      stateNext     = OCIOSO;
      contadorNext  = 8'd0;
      trocaNext     = 1'b0;
      numTrocasNext = numTrocasReg + 8'd1;
    end else begin
      case (state)
        OCIOSO: begin
          if (contaPasso) begin
            stateNext    = CONTANDO;
            contadorNext = 8'd1;
          end
        end
        CONTANDO: begin
          if (!usuario) begin
            // trap into the OS or voluntary return: the slice starts over
            stateNext    = OCIOSO;
            contadorNext = 8'd0;
          end else if (contaPasso) begin
            contadorNext = contador + 8'd1;
            if ((contador + 8'd1) == QUANTUM_C) begin
              if (cpu.instrucao_io || cpu.parada) begin
                stateNext = PENDENTE;
              end else begin
                stateNext   = REQ;
                trocaNext   = 1'b1;
                pcSalvoNext = cpu.pc;
              end
            end
          end
        end
        PENDENTE: begin
          // slice is used up; only waiting for the IN/OUT or halt to clear
          if (!cpu.instrucao_io && !cpu.parada) begin
            stateNext   = REQ;
            trocaNext   = 1'b1;
            pcSalvoNext = cpu.pc;
          end
        end
        REQ: begin
          // held until acknowledged or the process ends; OS-region pc does not cancel it
        end
        default: begin
          stateNext    = OCIOSO;
          contadorNext = 8'd0;
          trocaNext    = 1'b0;
        end
      endcase
    end
  end

  assign cpu.troca_contexto = trocaReg;
  assign cpu.pc_salvo       = pcSalvoReg;
  assign cpu.restante       = QUANTUM_C - contador;
  assign cpu.num_trocas     = numTrocasReg;

endmodule
